// File: rtl/data_sram_responder_pkg.sv
// Shared types and defaults for the data SRAM responder.
package data_sram_responder_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_e;

   localparam int DEF_LATENCY     = 1;
   localparam int DEF_OUTSTANDING = 2;
   localparam int CNT_W           = 3;

   typedef struct packed {
      logic        rd;
      logic [31:0] data;
      logic [3:0]  cnt;
   } resp_ent_t;

   // Countdown start value, saturated to the 4-bit field.
   function automatic logic [3:0] init_cnt(input int lat,
                                           input logic [2:0] extra);
      logic [4:0] s;
      s = 5'(lat - 1) + 5'(extra);
      return (s > 5'd15) ? 4'hF : s[3:0];
   endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Request/response bus between a core data port and the SRAM responder.
interface data_sram_responder_if;

   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_size,
      output data_sram_wstrb, data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size,
      input  data_sram_wstrb, data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

endinterface

// File: rtl/data_sram_responder_queue.sv
// In-order response queue; only the head entry counts down, and it
// pops by itself on the cycle its response is presented.
module sram_resp_queue
   import data_sram_responder_pkg::*;
#(
   parameter int DEPTH = DEF_OUTSTANDING
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  resp_ent_t        push_ent,
   output logic             resp_vld,
   output resp_ent_t        head,
   output logic [CNT_W-1:0] count
);

   resp_ent_t        ent_q [DEPTH];
   resp_ent_t        ent_d [DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] wr_idx;
   logic             head_vld;

   assign head_vld = (count_q != '0);
   assign resp_vld = head_vld && (ent_q[0].cnt == 4'd0);
   assign head     = ent_q[0];
   assign count    = count_q;

   always_comb begin
      ent_d   = ent_q;
      wr_idx  = count_q;
      count_d = count_q + CNT_W'(push) - CNT_W'(resp_vld);
      if (head_vld && ent_q[0].cnt != 4'd0)
         ent_d[0].cnt = ent_q[0].cnt - 4'd1;
      if (resp_vld) begin
         for (int i = 0; i < DEPTH - 1; i++)
            ent_d[i] = ent_q[i + 1];
         ent_d[DEPTH - 1] = '0;
         wr_idx = count_q - CNT_W'(1);
      end
      // Push lands after the shift so it never overwrites a live entry.
      if (push)
         for (int i = 0; i < DEPTH; i++)
            if (CNT_W'(i) == wr_idx)
               ent_d[i] = push_ent;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++)
            ent_q[i] <= '0;
      end else begin
         count_q <= count_d;
         ent_q   <= ent_d;
      end
   end

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM model with in-order, latency-controlled responses.
// Define SRAM_RAND_DELAY_EN to add LFSR-driven extra response delay.
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int MEM_AW      = 12,
   parameter int LATENCY     = DEF_LATENCY,
   parameter int OUTSTANDING = DEF_OUTSTANDING
) (
   input  logic                  clk,
   input  logic                  reset,
   data_sram_responder_if.slave  bus
);

   logic [31:0]       mem [2**MEM_AW];
   logic [MEM_AW-1:0] idx;
   logic              accept;
   logic              resp_vld;
   logic [2:0]        extra;
   logic [CNT_W-1:0]  count;
   resp_ent_t         push_ent;
   resp_ent_t         head;
   logic              unused_ok;

   assign idx       = bus.data_sram_addr[MEM_AW+1:2];
   assign unused_ok = ^{bus.data_sram_size,
                        bus.data_sram_addr[1:0],
                        bus.data_sram_addr[31:MEM_AW+2]};

   assign bus.data_sram_addr_ok = !reset &&
                                  (count < CNT_W'(OUTSTANDING));
   assign accept = bus.data_sram_req && bus.data_sram_addr_ok;

`ifdef SRAM_RAND_DELAY_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb
      lfsr_d = {lfsr_q[6:0],
                lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= 8'hA5;
      else       lfsr_q <= lfsr_d;
   end

   assign extra = lfsr_q[2:0];
`else
   assign extra = 3'd0;
`endif

   // Contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (accept && bus.data_sram_wr)
         for (int b = 0; b < 4; b++)
            if (bus.data_sram_wstrb[b])
               mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
   end

   always_comb begin
      push_ent      = '0;
      push_ent.rd   = !bus.data_sram_wr;
      push_ent.data = bus.data_sram_wr ? 32'h0 : mem[idx];
      push_ent.cnt  = init_cnt(LATENCY, extra);
   end

   sram_resp_queue #(
      .DEPTH (OUTSTANDING)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .push     (accept),
      .push_ent (push_ent),
      .resp_vld (resp_vld),
      .head     (head),
      .count    (count)
   );

   assign bus.data_sram_data_ok = resp_vld;
   assign bus.data_sram_rdata   = (resp_vld && head.rd) ? head.data
                                                        : 32'h0;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomised bench for data_sram_responder against a timing/memory model.
module tb_data_sram_responder;
   import data_sram_responder_pkg::*;

   localparam int AW   = 12;
   localparam int LAT  = 3;
   localparam int OUTS = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   data_sram_responder_if bus ();

   data_sram_responder #(
      .MEM_AW      (AW),
      .LATENCY     (LAT),
      .OUTSTANDING (OUTS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      int          pop_edge;
      bit          rd;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mem_m [2**AW];
   int          now      = 0;
   int          last_pop = 0;
   logic [7:0]  lfsr_m   = 8'hA5;
   int          n_chk    = 0;
   int          n_err    = 0;
   logic [31:0] last_rd  = 32'h0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int eff_lat();
`ifdef SRAM_RAND_DELAY_EN
      int x;
      x = LAT + int'(lfsr_m[2:0]);
      return (x > 16) ? 16 : x;
`else
      return LAT;
`endif
   endfunction

   // One bus cycle: drive, check outputs, then advance the model.
   task automatic cycle(input bit req, input bit wr,
                        input logic [3:0] st, input logic [31:0] a,
                        input logic [31:0] wd, output bit acc);
      bit              exp_aok, exp_dok;
      logic [31:0]     exp_rd;
      logic [AW-1:0]   idx;
      int              pe;
      bus.data_sram_req   = req;
      bus.data_sram_wr    = wr;
      bus.data_sram_size  = 2'(SIZE_WORD);
      bus.data_sram_wstrb = st;
      bus.data_sram_addr  = a;
      bus.data_sram_wdata = wd;
      #1;
      exp_aok = !reset && (q.size() < OUTS);
      exp_dok = !reset && (q.size() > 0) && (q[0].pop_edge == now);
      exp_rd  = (exp_dok && q[0].rd) ? q[0].data : 32'h0;
      chk("addr_ok", {31'b0, bus.data_sram_addr_ok}, {31'b0, exp_aok});
      chk("data_ok", {31'b0, bus.data_sram_data_ok}, {31'b0, exp_dok});
      chk("rdata", bus.data_sram_rdata, exp_rd);
      if (exp_dok && q[0].rd) last_rd = bus.data_sram_rdata;
      acc = req && exp_aok;
      @(posedge clk);
      if (reset) begin
         q.delete();
         last_pop = 0;
         lfsr_m   = 8'hA5;
      end else begin
         if (exp_dok) void'(q.pop_front());
         if (acc) begin
            idx = a[AW+1:2];
            pe  = ((now > last_pop) ? now : last_pop) + eff_lat();
            last_pop = pe;
            if (wr) begin
               for (int b = 0; b < 4; b++)
                  if (st[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
               q.push_back('{pe, 1'b0, 32'h0});
            end else begin
               q.push_back('{pe, 1'b1, mem_m[idx]});
            end
         end
         lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
      end
      now++;
      @(negedge clk);
   endtask

   task automatic idle();
      bit acc;
      cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, acc);
   endtask

   task automatic issue(input bit wr, input logic [3:0] st,
                        input logic [31:0] a, input logic [31:0] wd);
      bit acc;
      acc = 1'b0;
      for (int i = 0; i < 60 && !acc; i++)
         cycle(1'b1, wr, st, a, wd, acc);
      if (!acc) chk("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && q.size() > 0; i++) idle();
      chk("drain", q.size(), 32'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      reset = 1'b0;
   endtask

   initial begin
      bit acc;
      logic [31:0] a;
      @(negedge clk);
      idle();
      idle();
      reset = 1'b0;

      for (int w = 0; w < 16; w++)
         issue(1'b1, 4'hF, 32'(w * 4), $urandom);
      drain();

      issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      issue(1'b0, 4'h0, 32'h10, 32'h0);
      drain();
      chk("raw_read", last_rd, 32'hDEADBEEF);

      issue(1'b1, 4'hF, 32'h20, 32'h11223344);
      issue(1'b1, 4'b0100, 32'h20, 32'h00AB0000);
      issue(1'b0, 4'h0, 32'h20, 32'h0);
      drain();
      chk("lane_merge", last_rd, 32'h11AB3344);

      for (int i = 0; i < 3; i++)
         issue(1'b0, 4'h0, 32'(i * 4), 32'h0);
      drain();

      issue(1'b1, 4'hF, 32'h4, 32'hCAFEF00D);
      issue(1'b0, 4'h0, 32'h4, 32'h0);
      drain();
      chk("alias_base", last_rd, 32'hCAFEF00D);
      issue(1'b0, 4'h0, 32'h4004, 32'h0);
      drain();
      chk("alias_wrap", last_rd, 32'hCAFEF00D);

      issue(1'b1, 4'hF, 32'h8, 32'h5A5A1234);
      issue(1'b1, 4'h0, 32'h8, 32'hFFFFFFFF);
      issue(1'b0, 4'h0, 32'h8, 32'h0);
      drain();
      chk("null_strobe", last_rd, 32'h5A5A1234);

      issue(1'b0, 4'h0, 32'h0, 32'h0);
      issue(1'b0, 4'h0, 32'h4, 32'h0);
      do_reset();
      repeat (10) idle();
      issue(1'b0, 4'h0, 32'h8, 32'h0);
      drain();
      chk("persist", last_rd, 32'h5A5A1234);

      for (int i = 0; i < 300; i++) begin
         a = ($urandom & 32'hFFFF_C000) |
             32'($urandom_range(0, 15) << 2) |
             32'($urandom_range(0, 3));
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               4'($urandom), a, $urandom, acc);
      end
      drain();

      for (int i = 0; i < 100; i++)
         issue(1'b0, 4'h0, 32'($urandom_range(0, 15) << 2), 32'h0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 Parameter MEM_AW, 12, word-index width; memory holds 2^MEM_AW 32-bit words.
REQ-002 Parameter LATENCY, 1, minimum cycles from request acceptance to data_ok; legal range 1..15.
REQ-003 Parameter OUTSTANDING, 2, maximum accepted-but-unanswered requests; legal range 1..4.
REQ-004 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port data_sram_req  in  1  request valid.
REQ-007 Port data_sram_wr  in  1  1 = write, 0 = read.
REQ-008 Port data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational only.
REQ-009 Port data_sram_wstrb  in  4  byte write enables, bit i = byte lane i.
REQ-010 Port data_sram_addr  in  32  byte address.
REQ-011 Port data_sram_wdata  in  32  write data.
REQ-012 Port data_sram_addr_ok  out  1  request accepted this cycle when high together with req.
REQ-013 Port data_sram_data_ok  out  1  one-cycle response pulse.
REQ-014 Port data_sram_rdata  out  32  read data, valid while data_ok is high.

Function
REQ-015 Acceptance occurs on a rising edge where req and addr_ok are both high; addr_ok SHALL be high exactly when outstanding count < OUTSTANDING and reset is low; no same-cycle pop bypass.
REQ-016 Word index = addr[MEM_AW+1:2]; addr[1:0] and addr bits above MEM_AW+1 SHALL be ignored (higher addresses alias and wrap).
REQ-017 Writes SHALL update memory at the acceptance edge, only in lanes whose wstrb bit is set; wstrb = 0 is a legal no-op write that still receives a response.
REQ-018 Reads SHALL capture the memory word at the acceptance edge, after any earlier accepted write, giving in-order read-after-write semantics.
REQ-019 Accepted requests SHALL enter an in-order queue of depth OUTSTANDING holding type, captured read data and a 4-bit countdown initialised to LATENCY-1 plus extra delay (REQ-030).
REQ-020 The head entry's countdown SHALL decrement every cycle while non-zero; non-head entries do not count.
REQ-021 data_ok SHALL be high for exactly one cycle when the head entry is valid with countdown 0; the entry pops at the end of that cycle.
REQ-022 Request accepted at edge T with zero extra delay SHALL see data_ok during the cycle after edge T+LATENCY-1; consecutive responses never overlap and keep acceptance order.
REQ-023 rdata SHALL be the captured word for read responses and 32'h0 for write responses and whenever data_ok is low.
REQ-024 Simultaneous accept and pop SHALL leave the count unchanged; accept into an empty queue SHALL NOT produce data_ok in the same cycle.
REQ-025 The responder SHALL apply no backpressure on responses; the requester must consume every data_ok pulse.

Reset
REQ-026 While reset is high: addr_ok = 0, data_ok = 0, rdata = 32'h0, queue empty, count = 0.
REQ-027 Reset mid-operation SHALL discard all outstanding responses; writes already accepted SHALL persist; memory contents are never reset.

Configuration
REQ-028 Macro SRAM_RAND_DELAY_EN selects randomised response latency.
REQ-029 Without the macro, extra delay = 0 and latency is exactly LATENCY for every request.
REQ-030 With the macro, an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 8'hA5 on reset) SHALL advance every cycle, and each accepted request's extra delay = lfsr[2:0] sampled at acceptance, saturating the countdown at 15.

Structure
REQ-031 A shared header/package SHALL hold the size encodings (SIZE_BYTE/HALF/WORD) and the default LATENCY and OUTSTANDING values.
REQ-032 One sub-module, sram_resp_queue, SHALL implement the in-order response queue (push, pop, count, head countdown); the LFSR and memory array stay in the top module.

Verification
REQ-033 Write addr 32'h10, wstrb 4'hF, wdata 32'hDEADBEEF, then read 32'h10 -> two data_ok pulses in order, second rdata 32'hDEADBEEF, first rdata 32'h0.
REQ-034 Write wstrb 4'b0100, wdata 32'h00AB0000 over 32'h11223344, then read -> rdata 32'h11AB3344.
REQ-035 Hold req high for 3 reads with OUTSTANDING=2, LATENCY=3 -> addr_ok low after 2 acceptances until the first data_ok; 3 responses in order.
REQ-036 Read 32'h4 and 32'h4004 with MEM_AW=12 -> identical rdata (aliasing).
REQ-037 Assert reset for 1 cycle with 2 reads outstanding -> no data_ok afterwards; prior write still readable.
REQ-038 With SRAM_RAND_DELAY_EN, 100 back-to-back reads -> each latency in LATENCY..LATENCY+7, order preserved, rdata correct.
